// File: rtl/btb_update_gen.sv
// rtl/btb_update_gen.sv - BTB update producer: filters mispredicted indirect jumps into a FIFO
//
// Purpose: keeps only mispredicted indirect jumps resolved in execute, drops
// back-to-back duplicates, buffers survivors and issues one BTB update per cycle.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clr_i                    synchronous clear of all state
//   flush_i                  discard all pending updates
//   debug_mode_i, hold_i     stall the output (debug also discards resolutions)
//   resolve_*                resolved control-flow outcome from the branch unit
//   btb_update_o             head-of-FIFO update towards the frontend BTB
//   pending_o                FIFO occupancy
//   drop_cnt_o               saturating count of updates lost to overflow

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
  } btb_update_t;
endpackage

module btb_update_gen #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          flush_i,
  input  logic                          debug_mode_i,
  input  logic                          hold_i,
  input  logic                          resolve_valid_i,
  input  logic [riscv::VLEN-1:0]        resolve_pc_i,
  input  logic [riscv::VLEN-1:0]        resolve_target_i,
  input  logic                          resolve_is_indirect_i,
  input  logic                          resolve_mispredict_i,
  output ariane_pkg::btb_update_t       btb_update_o,
  output logic [$clog2(DEPTH):0]        pending_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [riscv::VLEN-1:0] pc_mem  [DEPTH];
  logic [riscv::VLEN-1:0] tgt_mem [DEPTH];

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [OCC_W-1:0]       count;
  logic [CNT_WIDTH-1:0]   drop_cnt;
  logic                   last_valid;
  logic [riscv::VLEN-1:0] last_pc, last_tgt;

  logic empty, full, candidate, dup, push_req, push, pop, drop;

  assign empty = (count == '0);
  assign full  = (count == OCC_FULL);

  assign candidate = resolve_valid_i && resolve_is_indirect_i && resolve_mispredict_i
                     && !debug_mode_i && !flush_i;
  assign dup       = last_valid && (resolve_pc_i == last_pc) && (resolve_target_i == last_tgt);
  assign push_req  = candidate && !dup && !clr_i;

  // Popping is the same condition as presenting a valid update: the BTB never stalls.
  assign pop  = !empty && !hold_i && !debug_mode_i && !flush_i && !clr_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  // Storage needs no reset; the output masks it whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]  <= resolve_pc_i;
      tgt_mem[wr_ptr] <= resolve_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      last_valid <= 1'b0;
      last_pc    <= '0;
      last_tgt   <= '0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      last_valid <= 1'b0;
      last_pc    <= '0;
      last_tgt   <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_valid <= 1'b1;
        last_pc    <= resolve_pc_i;
        last_tgt   <= resolve_target_i;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + OCC_ONE;
      end else if (pop && !push) begin
        count <= count - OCC_ONE;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    btb_update_o       = '0;
    btb_update_o.valid = pop;
    if (!empty) begin
      btb_update_o.pc             = pc_mem[rd_ptr];
      btb_update_o.target_address = tgt_mem[rd_ptr];
    end
  end

  assign pending_o  = count;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_btb_update_gen.sv
// tb/tb_btb_update_gen.sv - scoreboard bench for btb_update_gen
module tb_btb_update_gen;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    clr_i;
  logic                    flush_i;
  logic                    debug_mode_i;
  logic                    hold_i;
  logic                    resolve_valid_i;
  logic [63:0]             resolve_pc_i;
  logic [63:0]             resolve_target_i;
  logic                    resolve_is_indirect_i;
  logic                    resolve_mispredict_i;
  ariane_pkg::btb_update_t btb_update_o;
  logic [2:0]              pending_o;
  logic [7:0]              drop_cnt_o;

  btb_update_gen #(.DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .clr_i                 (clr_i),
    .flush_i               (flush_i),
    .debug_mode_i          (debug_mode_i),
    .hold_i                (hold_i),
    .resolve_valid_i       (resolve_valid_i),
    .resolve_pc_i          (resolve_pc_i),
    .resolve_target_i      (resolve_target_i),
    .resolve_is_indirect_i (resolve_is_indirect_i),
    .resolve_mispredict_i  (resolve_mispredict_i),
    .btb_update_o          (btb_update_o),
    .pending_o             (pending_o),
    .drop_cnt_o            (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every issued update must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && btb_update_o.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual_pc=%0h required=none", btb_update_o.pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("update_pc", btb_update_o.pc, e.pc);
        check("update_tgt", btb_update_o.target_address, e.tgt);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cand(input logic [63:0] pc, input logic [63:0] tgt);
    resolve_valid_i       = 1'b1;
    resolve_is_indirect_i = 1'b1;
    resolve_mispredict_i  = 1'b1;
    resolve_pc_i          = pc;
    resolve_target_i      = tgt;
  endtask

  task automatic idle_res();
    resolve_valid_i       = 1'b0;
    resolve_is_indirect_i = 1'b0;
    resolve_mispredict_i  = 1'b0;
    resolve_pc_i          = '0;
    resolve_target_i      = '0;
  endtask

  task automatic expect_upd(input logic [63:0] pc, input logic [63:0] tgt);
    exp_t e;
    e.pc  = pc;
    e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; hold_i = 1'b0;
    idle_res();
    step(); step();
    @(negedge clk_i);
    check("reset_valid", btb_update_o.valid, 0);
    check("reset_pending", pending_o, 0);
    check("reset_drop", drop_cnt_o, 0);
    check("reset_pc", btb_update_o.pc, 0);
    check("reset_tgt", btb_update_o.target_address, 0);
    rst_ni = 1'b1;
    step();

    // Single mispredicted JALR, visible the cycle after the push edge.
    cand(64'h8000_0100, 64'h8000_2000);
    expect_upd(64'h8000_0100, 64'h8000_2000);
    step();
    idle_res();
    @(negedge clk_i);
    check("t1_valid_next_cycle", btb_update_o.valid, 1);
    check("t1_pending_one", pending_o, 1);
    step();
    check("t1_pending_zero", pending_o, 0);
    check("t1_valid_gone", btb_update_o.valid, 0);

    // Same pc/target on 3 consecutive cycles: one update only.
    cand(64'h8000_0200, 64'h8000_3000);
    expect_upd(64'h8000_0200, 64'h8000_3000);
    repeat (3) step();
    idle_res();
    repeat (3) step();
    check("t2_drop", drop_cnt_o, 0);
    check("t2_pending", pending_o, 0);

    // Hold with 5 distinct candidates: 4 stored, 1 dropped.
    hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cand(64'h1000 + 64'(i) * 4, 64'h9000 + 64'(i) * 16);
      if (i < 4) expect_upd(64'h1000 + 64'(i) * 4, 64'h9000 + 64'(i) * 16);
      step();
    end
    idle_res();
    check("t3_pending_full", pending_o, 4);
    check("t3_drop_one", drop_cnt_o, 1);
    hold_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t3_consecutive_valid", btb_update_o.valid, 1);
      step();
    end
    check("t3_drained", pending_o, 0);

    // Flush with 3 pending and a candidate in the flush cycle.
    hold_i = 1'b1;
    cand(64'h3000, 64'hA000); step();
    cand(64'h3004, 64'hA010); step();
    cand(64'h3008, 64'hA020); step();
    check("t4_pending_three", pending_o, 3);
    hold_i  = 1'b0;
    flush_i = 1'b1;
    cand(64'h3010, 64'hA030);
    @(negedge clk_i);
    check("t4_flush_valid", btb_update_o.valid, 0);
    step();
    flush_i = 1'b0;
    idle_res();
    check("t4_flush_pending", pending_o, 0);
    // Last pushed entry re-presented: must be accepted since last_valid was cleared.
    cand(64'h3008, 64'hA020);
    expect_upd(64'h3008, 64'hA020);
    step();
    idle_res();
    @(negedge clk_i);
    check("t4_reaccept_valid", btb_update_o.valid, 1);
    step();
    check("t4_reaccept_drained", pending_o, 0);
    check("t4_drop_kept", drop_cnt_o, 1);

    // Debug-mode, non-indirect, and correctly-predicted resolutions are ignored.
    debug_mode_i = 1'b1;
    cand(64'h5000, 64'hB000);
    step();
    debug_mode_i = 1'b0;
    cand(64'h5004, 64'hB010);
    resolve_is_indirect_i = 1'b0;
    step();
    cand(64'h5008, 64'hB020);
    resolve_mispredict_i = 1'b0;
    step();
    idle_res();
    step();
    check("t5_pending", pending_o, 0);

    // Full FIFO, candidate every cycle with hold low: steady occupancy, no drops.
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cand(64'h6000 + 64'(i) * 4, 64'hC000 + 64'(i) * 4);
      expect_upd(64'h6000 + 64'(i) * 4, 64'hC000 + 64'(i) * 4);
      step();
    end
    hold_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cand(64'h7000 + 64'(i) * 8, 64'hD000 + 64'(i) * 8);
      expect_upd(64'h7000 + 64'(i) * 8, 64'hD000 + 64'(i) * 8);
      @(negedge clk_i);
      check("t6_valid_each_cycle", btb_update_o.valid, 1);
      step();
      check("t6_pending_steady", pending_o, 4);
    end
    idle_res();
    repeat (4) step();
    check("t6_drained", pending_o, 0);
    check("t6_no_new_drops", drop_cnt_o, 1);

    // Drop counter saturation, then synchronous clear.
    hold_i = 1'b1;
    for (int i = 0; i < 263; i++) begin
      cand(64'h4000_0000 + 64'(i) * 4, 64'h5000_0000 + 64'(i) * 4);
      step();
    end
    idle_res();
    check("sat_drop", drop_cnt_o, 255);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_pending", pending_o, 0);
    check("clr_drop", drop_cnt_o, 0);
    check("clr_pc_zero", btb_update_o.pc, 0);
    check("clr_tgt_zero", btb_update_o.target_address, 0);
    hold_i = 1'b0;
    cand(64'h4000_000C, 64'h5000_000C);
    expect_upd(64'h4000_000C, 64'h5000_000C);
    step();
    idle_res();
    step();
    check("clr_reaccept_drained", pending_o, 0);

    // Asynchronous reset mid-operation suppresses the pending update.
    hold_i = 1'b1;
    cand(64'h8800_0000, 64'h8800_1000);
    step();
    idle_res();
    hold_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("areset_valid", btb_update_o.valid, 0);
    check("areset_pending", pending_o, 0);
    step();
    rst_ni = 1'b1;
    repeat (2) step();

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
